// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: divided square wave clk_div plus a tick strobe at each period start.
// Optional CLK_DIV_PROG_SYNC_EN adds a sync input that forces a period restart to phase-align dividers.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic             div_load,
`ifdef CLK_DIV_PROG_SYNC_EN
  input  logic             sync,
`endif
  output logic             div_busy,
  output logic             div_err,
  output logic             clk_div,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] pend;
  logic             pend_v;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] high_len;
  logic             sync_hit;
  logic             wrap;
  logic             load_ok;
  logic             load_bad;

`ifdef CLK_DIV_PROG_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // cnt stays below act-1 on non-wrap edges, so cnt+1 never overflows WIDTH bits.
  assign cnt_inc  = cnt + ONE;
  // Subtracting the low half keeps odd ratios high-biased and avoids a WIDTH+1 carry.
  assign high_len = act - (act >> 1);
  assign wrap     = en && ((cnt == act - ONE) || sync_hit);
  assign load_ok  = div_load && (div_ratio >= TWO);
  assign load_bad = div_load && (div_ratio <  TWO);

  assign div_busy = pend_v;

  // NOTE: every register here is assigned with <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= DEF_RATIO - ONE;
      act     <= DEF_RATIO;
      pend    <= '0;
      pend_v  <= 1'b0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      tick    <= 1'b0;
      div_err <= load_bad;

      if (wrap) begin
        cnt     <= '0;
        clk_div <= 1'b1;
        tick    <= 1'b1;
        if (pend_v) begin
          act    <= pend;
          pend_v <= 1'b0;
        end
      end else if (en) begin
        cnt     <= cnt_inc;
        clk_div <= (cnt_inc < high_len);
      end

      // A load landing on a wrap bypasses the shadow and supersedes any older pending ratio.
      if (load_ok) begin
        if (wrap) begin
          act    <= div_ratio;
          pend_v <= 1'b0;
        end else begin
          pend   <= div_ratio;
          pend_v <= 1'b1;
        end
      end
    end
  end

endmodule
